// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, control-field widths and per-opcode
// control words used by the decode, execute and memory stages.
package pipe_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // wb = {RegWrite, MemtoReg}, m = {Branch, MemRead, MemWrite},
    // ex = {RegDst, ALUOp[1:0], ALUSrc}
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE  = '{wb: 2'b00, m: 3'b000, ex: 4'b0000};
    localparam ctrl_t CTRL_RTYPE = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
    localparam ctrl_t CTRL_LW    = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
    localparam ctrl_t CTRL_SW    = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
    localparam ctrl_t CTRL_BEQ   = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
    localparam ctrl_t CTRL_ADDI  = '{wb: 2'b10, m: 3'b000, ex: 4'b0001};

    // The all-zero word is a NOP and must not look like an R-type write.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = CTRL_NONE;
        if (instr == 32'd0) begin
            c = CTRL_NONE;
        end else begin
            case (instr[31:26])
                OP_RTYPE: c = CTRL_RTYPE;
                OP_LW:    c = CTRL_LW;
                OP_SW:    c = CTRL_SW;
                OP_BEQ:   c = CTRL_BEQ;
                OP_ADDI:  c = CTRL_ADDI;
                default:  c = CTRL_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile.sv
// Register file: one write port, two combinational read ports, register 0
// hardwired to zero, with same-cycle bypass of the writeback value.
module regfile
    import pipe_pkg::*;
#(
    parameter int NREG = 32,
    parameter int W    = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  wd_i,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic [W-1:0]  rd1_o,
    output logic [W-1:0]  rd2_o
);

    logic [W-1:0] regs_q [NREG];
    logic         wr_en_s;

    assign wr_en_s = we_i && (wa_i != {AW{1'b0}});

    // Storage update: synchronous clear, otherwise write when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {W{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read port 1 with zero register and writeback bypass.
    always_comb begin
        rd1_o = {W{1'b0}};
        if (ra1_i == {AW{1'b0}}) begin
            rd1_o = {W{1'b0}};
        end else if (wr_en_s && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end else begin
            rd1_o = regs_q[ra1_i];
        end
    end

    // Read port 2 with zero register and writeback bypass.
    always_comb begin
        rd2_o = {W{1'b0}};
        if (ra2_i == {AW{1'b0}}) begin
            rd2_o = {W{1'b0}};
        end else if (wr_en_s && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end else begin
            rd2_o = regs_q[ra2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, control decode, sign extension,
// load-use hazard detection and register-file reads feeding ID/EX.
module id_stage
    import pipe_pkg::*;
#(
    parameter int NREG = 32,
    parameter int W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     if_instr,
    input  logic [W-1:0]    if_pc4,
    input  logic            flush,
    input  logic            idex_mem_read,
    input  logic [4:0]      idex_rt,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [W-1:0]    wb_data,
    output logic            pc_write,
    output logic [4:0]      Rs,
    output logic [4:0]      Rt,
    output logic [4:0]      Rd,
    output logic [WB_W-1:0] WB,
    output logic [M_W-1:0]  M,
    output logic [EX_W-1:0] EX,
    output logic [W-1:0]    busA,
    output logic [W-1:0]    busB,
    output logic [W-1:0]    imd,
    output logic [W-1:0]    id_pc4
);

    logic [31:0]  ifid_instr_q;
    logic [31:0]  ifid_instr_d;
    logic [W-1:0] ifid_pc4_q;
    logic [W-1:0] ifid_pc4_d;
    logic [4:0]   rs_s;
    logic [4:0]   rt_s;
    logic         stall_s;
    ctrl_t        ctrl_s;

    assign rs_s = ifid_instr_q[25:21];
    assign rt_s = ifid_instr_q[20:16];

    // Conservative: compares Rt even for opcodes that never read it.
    assign stall_s = idex_mem_read && (idex_rt != 5'd0) &&
                     ((idex_rt == rs_s) || (idex_rt == rt_s));

    // IF/ID next state: flush beats stall, stall holds, otherwise load.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        if (flush) begin
            ifid_instr_d = 32'd0;
            ifid_pc4_d   = if_pc4;
        end else if (stall_s) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
        end else begin
            ifid_instr_d = if_instr;
            ifid_pc4_d   = if_pc4;
        end
    end

    // IF/ID register with synchronous reset overriding flush and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr_q <= 32'd0;
            ifid_pc4_q   <= {W{1'b0}};
        end else begin
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    // Control decode with bubble injection while the hazard is present.
    always_comb begin
        ctrl_s = CTRL_NONE;
        if (stall_s) begin
            ctrl_s = CTRL_NONE;
        end else begin
            ctrl_s = decode_ctrl(ifid_instr_q);
        end
    end

    assign pc_write = !stall_s || flush;
    assign Rs       = rs_s;
    assign Rt       = rt_s;
    assign Rd       = ifid_instr_q[15:11];
    assign WB       = ctrl_s.wb;
    assign M        = ctrl_s.m;
    assign EX       = ctrl_s.ex;
    assign imd      = {{(W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    assign id_pc4   = ifid_pc4_q;

    regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we_i  (wb_reg_write),
        .wa_i  (wb_rd),
        .wd_i  (wb_data),
        .ra1_i (rs_s),
        .ra2_i (rt_s),
        .rd1_o (busA),
        .rd2_o (busB)
    );

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table followed by
// randomized traffic compared against a behavioural reference model.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        flush;
    logic        idex_mem_read;
    logic [4:0]  idex_rt;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        pc_write;
    logic [4:0]  Rs, Rt, Rd;
    logic [1:0]  WB;
    logic [2:0]  M;
    logic [3:0]  EX;
    logic [31:0] busA, busB, imd, id_pc4;

    int n_chk  = 0;
    int n_fail = 0;

    id_stage #(.NREG(32), .W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_instr      (if_instr),
        .if_pc4        (if_pc4),
        .flush         (flush),
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .pc_write      (pc_write),
        .Rs            (Rs),
        .Rt            (Rt),
        .Rd            (Rd),
        .WB            (WB),
        .M             (M),
        .EX            (EX),
        .busA          (busA),
        .busB          (busB),
        .imd           (imd),
        .id_pc4        (id_pc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        flush;
        logic        mr;
        logic [4:0]  irt;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        pcw;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] busa, busb, imd, pc4o;
    } vec_t;

    vec_t vecs [11];

    // Reference model state
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [31:0] m_regs [32];
    bit          m_valid;

    // Control word {WB, M, EX} as listed in the decode table.
    function automatic logic [8:0] ctrl_of(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (ins == 32'd0) return 9'b0;
        if (op == 6'h00) return 9'b10_000_1100;
        if (op == 6'h23) return 9'b11_010_0001;
        if (op == 6'h2B) return 9'b00_001_0001;
        if (op == 6'h04) return 9'b00_100_0010;
        if (op == 6'h08) return 9'b10_000_0001;
        return 9'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_reg_write && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    task automatic drive(input logic r, input logic [31:0] ins, input logic [31:0] p4,
                         input logic fl, input logic mr, input logic [4:0] irt,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        rst = r; if_instr = ins; if_pc4 = p4; flush = fl;
        idex_mem_read = mr; idex_rt = irt;
        wb_reg_write = we; wb_rd = wrd; wb_data = wd;
    endtask

    task automatic model_check();
        logic [4:0]  rs, rt;
        logic        st;
        logic [8:0]  c;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        st = idex_mem_read && (idex_rt != 5'd0) && (idex_rt == rs || idex_rt == rt);
        c  = st ? 9'b0 : ctrl_of(m_instr);
        chk("rnd_pc_write", {31'd0, pc_write}, {31'd0, !(st && !flush)});
        chk("rnd_Rs", {27'd0, Rs}, {27'd0, rs});
        chk("rnd_Rt", {27'd0, Rt}, {27'd0, rt});
        chk("rnd_Rd", {27'd0, Rd}, {27'd0, m_instr[15:11]});
        chk("rnd_ctrl", {23'd0, WB, M, EX}, {23'd0, c});
        chk("rnd_busA", busA, m_read(rs));
        chk("rnd_busB", busB, m_read(rt));
        chk("rnd_imd", imd, 32'($signed(m_instr[15:0])));
        chk("rnd_id_pc4", id_pc4, m_pc4);
    endtask

    task automatic model_update();
        logic [4:0] rs, rt;
        logic       st;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        st = idex_mem_read && (idex_rt != 5'd0) && (idex_rt == rs || idex_rt == rt);
        if (rst) begin
            m_instr = 32'd0;
            m_pc4   = 32'd0;
            for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
            m_valid = 1'b1;
        end else begin
            if (wb_reg_write && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            if (flush) begin
                m_instr = 32'd0;
                m_pc4   = if_pc4;
            end else if (!st) begin
                m_instr = if_instr;
                m_pc4   = if_pc4;
            end
        end
    endtask

    initial begin
        logic [5:0]  ops [6];
        logic [31:0] ins, rv;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h3F;
        m_valid = 1'b0;

        //          rst   instr          pc4         fl    mr    irt   we    wrd   wdata           pcw   rs    rt    rd     wb     m       ex       busa           busb   imd            pc4o
        vecs[0]  = '{1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 32'd5,          1'b1, 5'd0, 5'd0, 5'd0,  2'b00, 3'b000, 4'b0000, 32'h0,         32'h0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 32'h0,        32'h0,      1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 32'd7,          1'b1, 5'd0, 5'd0, 5'd0,  2'b00, 3'b000, 4'b0000, 32'h0,         32'h0, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 32'h00221820, 32'h104,    1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd0, 5'd0, 5'd0,  2'b00, 3'b000, 4'b0000, 32'h0,         32'h0, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 32'h8C24FFF8, 32'h108,    1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0,          1'b0, 5'd1, 5'd2, 5'd3,  2'b00, 3'b000, 4'b0000, 32'd5,         32'd7, 32'h1820,      32'h104};
        vecs[4]  = '{1'b0, 32'h8C24FFF8, 32'h108,    1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd1, 5'd2, 5'd3,  2'b10, 3'b000, 4'b1100, 32'd5,         32'd7, 32'h1820,      32'h104};
        vecs[5]  = '{1'b0, 32'h00221820, 32'h10C,    1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd1, 5'd4, 5'd31, 2'b11, 3'b010, 4'b0001, 32'd5,         32'd0, 32'hFFFFFFF8,  32'h108};
        vecs[6]  = '{1'b0, 32'h12345678, 32'h110,    1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 32'h0,          1'b1, 5'd1, 5'd2, 5'd3,  2'b00, 3'b000, 4'b0000, 32'd5,         32'd7, 32'h1820,      32'h10C};
        vecs[7]  = '{1'b0, 32'h00221820, 32'h114,    1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd0, 5'd0, 5'd0,  2'b00, 3'b000, 4'b0000, 32'h0,         32'h0, 32'h0,         32'h110};
        vecs[8]  = '{1'b0, 32'h0,        32'h118,    1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 32'hDEADBEEF,   1'b1, 5'd1, 5'd2, 5'd3,  2'b10, 3'b000, 4'b1100, 32'hDEADBEEF,  32'd7, 32'h1820,      32'h114};
        vecs[9]  = '{1'b0, 32'h00201820, 32'h11C,    1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hCAFEF00D,   1'b1, 5'd0, 5'd0, 5'd0,  2'b00, 3'b000, 4'b0000, 32'h0,         32'h0, 32'h0,         32'h118};
        vecs[10] = '{1'b0, 32'h0,        32'h120,    1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 32'h0,          1'b1, 5'd1, 5'd0, 5'd3,  2'b10, 3'b000, 4'b1100, 32'hDEADBEEF,  32'h0, 32'h1820,      32'h11C};

        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].instr, vecs[i].pc4, vecs[i].flush, vecs[i].mr,
                  vecs[i].irt, vecs[i].we, vecs[i].wrd, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d_pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].pcw});
            chk($sformatf("v%0d_Rs", i), {27'd0, Rs}, {27'd0, vecs[i].rs});
            chk($sformatf("v%0d_Rt", i), {27'd0, Rt}, {27'd0, vecs[i].rt});
            chk($sformatf("v%0d_Rd", i), {27'd0, Rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_WB", i), {30'd0, WB}, {30'd0, vecs[i].wb});
            chk($sformatf("v%0d_M", i), {29'd0, M}, {29'd0, vecs[i].m});
            chk($sformatf("v%0d_EX", i), {28'd0, EX}, {28'd0, vecs[i].ex});
            chk($sformatf("v%0d_busA", i), busA, vecs[i].busa);
            chk($sformatf("v%0d_busB", i), busB, vecs[i].busb);
            chk($sformatf("v%0d_imd", i), imd, vecs[i].imd);
            chk($sformatf("v%0d_id_pc4", i), id_pc4, vecs[i].pc4o);
            @(posedge clk);
            #1;
        end

        // Reset asserted together with flush and a stall condition.
        drive(1'b1, 32'h00221820, 32'h200, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("rst_over_flush_pc4", id_pc4, 32'h0);
        chk("rst_over_flush_busA", busA, 32'h0);
        chk("rst_over_flush_pc_write", {31'd0, pc_write}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 600; i++) begin
            rv  = $urandom;
            ins = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), rv[15:0]};
            if ($urandom_range(0, 9) == 0) ins = 32'd0;
            drive((i == 0) || ($urandom_range(0, 49) == 0), ins, $urandom,
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom);
            @(negedge clk);
            if (m_valid) model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
